// File: rtl/pam4_pkg.sv
// Shared types and constants for the PAM-4 transmit link sequencer.
// Symbol type, sequencer state encoding and training pattern symbols.
package pam4_pkg;

  typedef logic [1:0] pam4_sym_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_TRAIN = 2'd1,
    SEQ_DATA  = 2'd2
  } seq_state_t;

  localparam pam4_sym_t PAM4_SYM_MIN = 2'b00;
  localparam pam4_sym_t PAM4_SYM_MAX = 2'b11;

  // Preamble alternates MIN/MAX, starting with MIN at k=0.
  function automatic pam4_sym_t train_sym(input logic odd);
    return odd ? PAM4_SYM_MAX : PAM4_SYM_MIN;
  endfunction

endpackage

// File: rtl/pam4_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req at or after ptr.
// Ports: req/ptr/en in; one-hot gnt and its index gnt_idx out.
module pam4_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          w_found;
  logic [IW-1:0] w_idx;
  int            w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      w_idx = IW'(w_j);
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/pam4_tx_link_sequencer.sv
// PAM-4 TX link sequencer: training preamble, then round-robin symbol mux.
// Ports: clk, rstn (sync, active-low), enable, retrain, req_symbol,
//   req_valid, req_ready, symbol_out, symbol_out_valid, grant_id,
//   training_active, sym_count (only when PAM4_SEQ_STATS_EN is defined).
module pam4_tx_link_sequencer
  import pam4_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TRAIN_LEN = 16,
  parameter  int CNT_W     = 32,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int TW        = $clog2(TRAIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 retrain,
  input  logic [2*NUM_REQ-1:0] req_symbol,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [1:0]           symbol_out,
  output logic                 symbol_out_valid,
  output logic [IW-1:0]        grant_id,
  output logic                 training_active
`ifdef PAM4_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]     sym_count
`endif
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [IW-1:0] r_ptr;
  logic [TW-1:0] r_k;
  pam4_sym_t     r_sym;
  logic          r_valid;
  logic [IW-1:0] r_gid;
  logic          r_train;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gidx;
  logic               w_xfer;
  logic               w_emit_train;
  logic               w_enter_train;
  pam4_sym_t          w_syms [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_syms
    assign w_syms[gi] = req_symbol[2*gi +: 2];
  end

  pam4_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (enable && (r_state == SEQ_DATA)),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  assign req_ready     = w_gnt;
  assign w_xfer        = |w_gnt;
  assign w_emit_train  = enable && (r_state == SEQ_TRAIN);
  assign w_enter_train = (w_next == SEQ_TRAIN) && (r_state != SEQ_TRAIN);

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = SEQ_IDLE;
    end else begin
      unique case (r_state)
        SEQ_IDLE:  w_next = SEQ_TRAIN;
        SEQ_TRAIN: if (r_k == TW'(TRAIN_LEN - 1)) w_next = SEQ_DATA;
        SEQ_DATA:  if (retrain) w_next = SEQ_TRAIN;
        default:   w_next = SEQ_IDLE;
      endcase
    end
  end

  // Outputs lag the cycle that produced them by one: a preamble symbol k is
  // emitted the cycle after TRAIN with counter k, data the cycle after the
  // handshake. This lets a transfer in the retrain cycle land cleanly.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= SEQ_IDLE;
      r_ptr   <= '0;
      r_k     <= '0;
      r_sym   <= '0;
      r_valid <= 1'b0;
      r_gid   <= '0;
      r_train <= 1'b0;
    end else begin
      r_state <= w_next;
      r_train <= w_emit_train;
      if (w_enter_train) r_k <= '0;
      else if (w_emit_train) r_k <= r_k + 1'b1;
      if (w_emit_train) begin
        r_sym   <= train_sym(r_k[0]);
        r_valid <= 1'b1;
        r_gid   <= '0;
      end else if (w_xfer) begin
        r_sym   <= w_syms[w_gidx];
        r_valid <= 1'b1;
        r_gid   <= w_gidx;
        r_ptr   <= (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign symbol_out       = r_sym;
  assign symbol_out_valid = r_valid;
  assign grant_id         = r_gid;
  assign training_active  = r_train;

`ifdef PAM4_SEQ_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a transfer in the retrain cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_enter_train) begin
      r_cnt <= '0;
    end else if (w_xfer && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sym_count = r_cnt;
`endif

endmodule
